// File: rtl/fu_alu_dispatch_queue.sv
// Queues ALU requests, runs the external ALU CSR handshake back-to-back and buffers results.
// Latency: request -> ALU load >= 1 cycle; backpressure: req_ready low when full, COMPUTING stalls on full result FIFO.
module fu_alu_dispatch_queue #(
  parameter int DATA_W    = 32,
  parameter int OP_W      = 4,
  parameter int REQ_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [OP_W-1:0]                req_aluop,
  input  logic [DATA_W-1:0]              req_op1,
  input  logic [DATA_W-1:0]              req_op2,
  output logic                           res_valid,
  output logic [DATA_W-1:0]              res_data,
  input  logic                           res_pop,
  output logic [OP_W-1:0]                alu_aluop,
  output logic [DATA_W-1:0]              alu_op1,
  output logic [DATA_W-1:0]              alu_op2,
  input  logic [DATA_W-1:0]              alu_op3,
  output logic [2:0]                     alu_csr_in,
  input  logic [2:0]                     alu_csr_out,
  output logic [$clog2(REQ_DEPTH+1)-1:0] req_count,
  output logic [$clog2(RES_DEPTH+1)-1:0] res_count,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int RQ_AW = $clog2(REQ_DEPTH);
  localparam int RS_AW = $clog2(RES_DEPTH);
  localparam int RQ_CW = $clog2(REQ_DEPTH+1);
  localparam int RS_CW = $clog2(RES_DEPTH+1);
  localparam int WD_W  = $clog2(TIMEOUT+1);

  typedef enum logic [2:0] {
    IDLE, WAIT_OP1, LOAD_OP1, WAIT_OP2, LOAD_OP2, COMPUTING, CAPTURE
  } state_e;

  logic [OP_W-1:0]   rq_op_q [REQ_DEPTH];
  logic [DATA_W-1:0] rq_a_q  [REQ_DEPTH];
  logic [DATA_W-1:0] rq_b_q  [REQ_DEPTH];
  logic [RQ_AW-1:0]  rq_wr_q, rq_rd_q;
  logic [RQ_CW-1:0]  rq_cnt_q;

  logic [DATA_W-1:0] rs_mem_q [RES_DEPTH];
  logic [RS_AW-1:0]  rs_wr_q, rs_rd_q;
  logic [RS_CW-1:0]  rs_cnt_q;

  state_e            state_q;
  logic [WD_W-1:0]   wdog_q;
  logic [2:0]        csr_q;
  logic [OP_W-1:0]   aluop_q;
  logic [DATA_W-1:0] op1_q, op2_q;
  logic              terr_q;

  logic rq_push, rq_pop, rs_push, rs_pop, rs_full;
  logic in_wait, progress, wd_freeze, wd_fire;

  assign req_ready = (rq_cnt_q != RQ_CW'(REQ_DEPTH));
  assign rq_push   = req_valid && req_ready;
  assign rs_full   = (rs_cnt_q == RS_CW'(RES_DEPTH));
  assign res_valid = (rs_cnt_q != '0);
  assign rs_pop    = res_pop && res_valid;
  assign rs_push   = (state_q == CAPTURE);

  assign in_wait   = (state_q == WAIT_OP1) || (state_q == WAIT_OP2) || (state_q == COMPUTING);
  assign progress  = ((state_q == WAIT_OP1) && alu_csr_out[0]) ||
                     ((state_q == WAIT_OP2) && alu_csr_out[1]) ||
                     ((state_q == COMPUTING) && alu_csr_out[2] && !rs_full);
  // Result ready but nowhere to put it: this is backpressure, not an ALU hang.
  assign wd_freeze = (state_q == COMPUTING) && alu_csr_out[2] && rs_full;
  assign wd_fire   = in_wait && !progress && !wd_freeze && (wdog_q == WD_W'(TIMEOUT-1));
  assign rq_pop    = rs_push || wd_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      rq_wr_q  <= '0;
      rq_rd_q  <= '0;
      rq_cnt_q <= '0;
    end else begin
      if (rq_push) rq_wr_q <= rq_wr_q + 1'b1;
      if (rq_pop)  rq_rd_q <= rq_rd_q + 1'b1;
      rq_cnt_q <= rq_cnt_q + RQ_CW'(rq_push) - RQ_CW'(rq_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rq_push) begin
      rq_op_q[rq_wr_q] <= req_aluop;
      rq_a_q[rq_wr_q]  <= req_op1;
      rq_b_q[rq_wr_q]  <= req_op2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_wr_q  <= '0;
      rs_rd_q  <= '0;
      rs_cnt_q <= '0;
    end else begin
      if (rs_push) rs_wr_q <= rs_wr_q + 1'b1;
      if (rs_pop)  rs_rd_q <= rs_rd_q + 1'b1;
      rs_cnt_q <= rs_cnt_q + RS_CW'(rs_push) - RS_CW'(rs_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rs_push) rs_mem_q[rs_wr_q] <= alu_op3;
  end

  assign res_data = res_valid ? rs_mem_q[rs_rd_q] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wdog_q  <= '0;
      csr_q   <= '0;
      aluop_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      terr_q  <= 1'b0;
    end else if (wd_fire) begin
      state_q <= IDLE;
      wdog_q  <= '0;
      csr_q   <= '0;
      terr_q  <= 1'b1;
    end else begin
      // Any state change (progress) or leaving the wait states restarts the watchdog.
      if (in_wait && !progress) begin
        if (!wd_freeze) wdog_q <= wdog_q + 1'b1;
      end else begin
        wdog_q <= '0;
      end
      case (state_q)
        IDLE: if (rq_cnt_q != '0) begin
          aluop_q <= rq_op_q[rq_rd_q];
          op1_q   <= rq_a_q[rq_rd_q];
          op2_q   <= rq_b_q[rq_rd_q];
          state_q <= WAIT_OP1;
        end
        WAIT_OP1: if (alu_csr_out[0]) begin
          csr_q[1] <= 1'b1;
          state_q  <= LOAD_OP1;
        end
        LOAD_OP1: begin
          csr_q[1] <= 1'b0;
          state_q  <= WAIT_OP2;
        end
        WAIT_OP2: if (alu_csr_out[1]) begin
          csr_q[2] <= 1'b1;
          state_q  <= LOAD_OP2;
        end
        LOAD_OP2: begin
          csr_q[2] <= 1'b0;
          state_q  <= COMPUTING;
        end
        COMPUTING: if (alu_csr_out[2] && !rs_full) begin
          csr_q[0] <= 1'b1;
          state_q  <= CAPTURE;
        end
        CAPTURE: begin
          csr_q[0] <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_aluop   = aluop_q;
  assign alu_op1     = op1_q;
  assign alu_op2     = op2_q;
  assign alu_csr_in  = csr_q;
  assign req_count   = rq_cnt_q;
  assign res_count   = rs_cnt_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_fu_alu_dispatch_queue.sv
// Bench for fu_alu_dispatch_queue: behavioural external ALU plus an in-order expected-result queue.
module tb_fu_alu_dispatch_queue;
  localparam int TIMEOUT = 64;

  logic        clk, reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_aluop;
  logic [31:0] req_op1, req_op2;
  logic        res_valid, res_pop;
  logic [31:0] res_data;
  logic [3:0]  alu_aluop;
  logic [31:0] alu_op1, alu_op2, alu_op3;
  logic [2:0]  alu_csr_in, alu_csr_out;
  logic [2:0]  req_count, res_count;
  logic        busy, timeout_err;

  fu_alu_dispatch_queue #(.DATA_W(32), .OP_W(4), .REQ_DEPTH(4), .RES_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_aluop(req_aluop),
    .req_op1(req_op1), .req_op2(req_op2),
    .res_valid(res_valid), .res_data(res_data), .res_pop(res_pop),
    .alu_aluop(alu_aluop), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op3(alu_op3),
    .alu_csr_in(alu_csr_in), .alu_csr_out(alu_csr_out),
    .req_count(req_count), .res_count(res_count),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // External ALU: answers each handshake step after a random delay of 0..dly_max cycles.
  int          ph, dly, dly_max;
  bit          stall_op2, stall_res;
  logic [31:0] la, lb;
  logic [3:0]  lop;
  always @(negedge clk) begin
    if (reset || (!busy && ph != 0 && ph != 3)) begin
      ph = 0; dly = 0; alu_csr_out = 3'b000;
    end else begin
      case (ph)
        0: if (alu_csr_in[1]) begin
             la = alu_op1; alu_csr_out[0] = 1'b0; ph = 1; dly = $urandom_range(dly_max, 0);
           end else if (dly > 0) dly--;
           else alu_csr_out[0] = 1'b1;
        1: if (alu_csr_in[2]) begin
             lb = alu_op2; lop = alu_aluop; alu_csr_out[1] = 1'b0; ph = 2; dly = $urandom_range(dly_max, 0) + 2;
           end else if (dly > 0) dly--;
           else if (!stall_op2) alu_csr_out[1] = 1'b1;
        2: if (dly > 0) dly--;
           else if (!stall_res) begin
             alu_op3 = alu_f(lop, la, lb); alu_csr_out[2] = 1'b1; ph = 3;
           end
        default: if (alu_csr_in[0]) begin
             alu_csr_out[2] = 1'b0; ph = 0; dly = $urandom_range(dly_max, 0);
           end
      endcase
    end
  end

  // Width of the most recent csr_in[1]/[2] pulses, and how many pulses were not exactly one cycle.
  int w1, w2, w1_last, w2_last, bad_w;
  always @(negedge clk) begin
    if (alu_csr_in[1]) w1++;
    else if (w1 != 0) begin w1_last = w1; if (w1 != 1) bad_w++; w1 = 0; end
    if (alu_csr_in[2]) w2++;
    else if (w2 != 0) begin w2_last = w2; if (w2 != 1) bad_w++; w2 = 0; end
  end

  task automatic push_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit expect_res);
    int t = 0;
    while (!req_ready && t < 1000) begin @(negedge clk); t++; end
    chk("push_ready", req_ready, 1);
    req_valid = 1'b1; req_aluop = op; req_op1 = a; req_op2 = b;
    if (expect_res) exp_q.push_back(alu_f(op, a, b));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic pop_one();
    logic [31:0] e;
    e = exp_q.pop_front();
    chk("pop_valid", res_valid, 1);
    chk("res_data", res_data, e);
    res_pop = 1'b1;
    @(negedge clk);
    res_pop = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 5000) begin
      if (res_valid) pop_one();
      else begin @(negedge clk); t++; end
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic settle(input int n_res);
    int t = 0;
    while (t < 3000 && !(!busy && req_count == 0 && res_count == 3'(n_res))) begin
      @(negedge clk); t++;
    end
    chk("settle_busy", busy, 0);
    chk("settle_res_count", res_count, n_res);
  endtask

  initial begin
    int t, cnt, sent, rc, sc;
    reset = 1'b1; req_valid = 1'b0; req_aluop = '0; req_op1 = '0; req_op2 = '0; res_pop = 1'b0;
    dly_max = 0; stall_op2 = 1'b0; stall_res = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_csr_in", alu_csr_in, 0);
    chk("rst_alu_regs", {alu_aluop, alu_op1, alu_op2}, 0);
    chk("rst_counts", {req_count, res_count}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);

    // Single ADD 5+7
    push_req(4'd0, 32'd5, 32'd7, 1'b1);
    settle(1);
    chk("single_res", res_data, 32'd12);
    chk("single_csr1_w", w1_last, 1);
    chk("single_csr2_w", w2_last, 1);
    pop_one();
    chk("single_empty", res_valid, 0);

    // Burst of four
    for (int i = 1; i <= 4; i++) push_req(4'd0, 32'(i), 32'(i), 1'b1);
    chk("burst_ready", req_ready, 0);
    chk("burst_req_count", req_count, 4);
    settle(4);
    for (int i = 1; i <= 4; i++) begin
      chk("burst_order", res_data, 32'(2 * i));
      pop_one();
    end

    // Push and pop in the same cycle as CAPTURE
    push_req(4'd0, 32'd1, 32'd2, 1'b1);
    push_req(4'd0, 32'd10, 32'd20, 1'b1);
    t = 0;
    while (t < 1000 && !(alu_csr_in[0] && res_count == 1 && req_count == 1)) begin @(negedge clk); t++; end
    chk("simul_reached", t < 1000, 1);
    rc = req_count; sc = res_count;
    req_valid = 1'b1; req_aluop = 4'd4; req_op1 = 32'hF0; req_op2 = 32'hFF;
    chk("simul_head", res_data, exp_q.pop_front());
    exp_q.push_back(alu_f(4'd4, 32'hF0, 32'hFF));
    res_pop = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; res_pop = 1'b0;
    chk("simul_req_count", req_count, rc);
    chk("simul_res_count", res_count, sc);
    settle(2);
    drain();

    // Result backpressure: six requests, no pops
    for (int i = 0; i < 6; i++) push_req(4'd3, 32'(i << 4), 32'(i), 1'b1);
    repeat (200) @(negedge clk);
    chk("bp_res_count", res_count, 4);
    chk("bp_req_count", req_count, 2);
    chk("bp_csr_in", alu_csr_in, 0);
    chk("bp_busy", busy, 1);
    chk("bp_no_timeout", timeout_err, 0);
    pop_one();
    repeat (30) @(negedge clk);
    chk("bp_refill", res_count, 4);
    chk("bp_req_left", req_count, 1);
    drain();
    settle(0);

    // Randomised traffic with random ALU latency and random pops
    dly_max = 4; sent = 0;
    for (int cyc = 0; cyc < 8000 && (sent < 40 || exp_q.size() > 0); cyc++) begin
      if (sent < 40 && req_ready && $urandom_range(99, 0) < 60) begin
        req_valid = 1'b1; req_aluop = 4'($urandom_range(4, 0)); req_op1 = $urandom; req_op2 = $urandom;
        exp_q.push_back(alu_f(req_aluop, req_op1, req_op2));
        sent++;
      end else req_valid = 1'b0;
      if (res_valid && exp_q.size() > 0 && $urandom_range(1, 0) == 1) begin
        chk("rand_res", res_data, exp_q.pop_front());
        res_pop = 1'b1;
      end else res_pop = 1'b0;
      @(negedge clk);
    end
    req_valid = 1'b0; res_pop = 1'b0;
    chk("rand_sent", sent, 40);
    chk("rand_left", exp_q.size(), 0);
    settle(0);
    dly_max = 0;

    // Watchdog: ALU never signals OP2 ready
    stall_op2 = 1'b1;
    push_req(4'd0, 32'd100, 32'd1, 1'b0);
    t = 0;
    while (t < 500 && !alu_csr_in[1]) begin @(negedge clk); t++; end
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!timeout_err && cnt < 500);
    chk("tmo_cycles", cnt, TIMEOUT + 1);
    chk("tmo_csr_in", alu_csr_in, 0);
    chk("tmo_busy", busy, 0);
    chk("tmo_req_count", req_count, 0);
    chk("tmo_res_count", res_count, 0);
    stall_op2 = 1'b0;
    push_req(4'd1, 32'd9, 32'd4, 1'b1);
    settle(1);
    chk("tmo_next_res", res_data, 32'd5);
    pop_one();
    chk("tmo_sticky", timeout_err, 1);

    // Reset while COMPUTING with two more queued
    stall_res = 1'b1;
    for (int i = 0; i < 3; i++) push_req(4'd0, 32'(i), 32'd1, 1'b0);
    t = 0;
    while (t < 500 && !alu_csr_in[2]) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("rstop_req_count", req_count, 3);
    chk("rstop_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stall_res = 1'b0;
    chk("rstop_counts", {req_count, res_count}, 0);
    chk("rstop_csr_in", alu_csr_in, 0);
    chk("rstop_busy_low", busy, 0);
    chk("rstop_res_valid", res_valid, 0);
    chk("rstop_terr", timeout_err, 0);
    repeat (20) @(negedge clk);
    chk("rstop_stays_idle", busy, 0);
    chk("csr_pulse_width_bad", bad_w, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
